// File: rtl/mips_alu_if.sv
// mips_alu_if: operand/result bundle for the EXE-stage ALU.
// Define ALU_STICKY_OVF_EN to add the ovf_clr/ovf_sticky pair.
interface mips_alu_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             zero_flag;
    logic             overflow;
`ifdef ALU_STICKY_OVF_EN
    logic             ovf_clr;
    logic             ovf_sticky;
    modport master (output data1, data2, alu_op, ovf_clr, input alu_result, zero_flag, overflow, ovf_sticky);
    modport slave  (input data1, data2, alu_op, ovf_clr, output alu_result, zero_flag, overflow, ovf_sticky);
`else
    modport master (output data1, data2, alu_op, input alu_result, zero_flag, overflow);
    modport slave  (input data1, data2, alu_op, output alu_result, zero_flag, overflow);
`endif
endinterface

// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit MIPS ALU, one op per cycle, 1-cycle latency.
// Define ALU_STICKY_OVF_EN to add a sticky overflow flag cleared by ovf_clr.
module mips_alu #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    mips_alu_if.slave   bus
);
    logic [WIDTH-1:0] a, b, sum, diff, res_d, res_q;
    logic [4:0]       sh;
    logic             ovf_d, ovf_q, zero_d, zero_q;
    assign a    = bus.data1;
    assign b    = bus.data2;
    assign sh   = a[4:0];
    assign sum  = a + b;
    assign diff = a - b;
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (bus.alu_op)
            4'b0000: res_d = a & b;
            4'b0001: res_d = a | b;
            4'b0010: begin
                res_d = sum;
                ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0011: res_d = a ^ b;
            4'b0100: res_d = ~(a | b);
            4'b0101: res_d = sum;
            4'b0110: begin
                res_d = diff;
                ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: res_d = b << sh;
            4'b1001: res_d = b >> sh;
            4'b1010: res_d = $signed(b) >>> sh;
            4'b1011: res_d = {{(WIDTH-1){1'b0}}, a < b};
            4'b1100: res_d = diff;
            4'b1101: res_d = WIDTH'({b[15:0], 16'h0});
            4'b1110: res_d = b;
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end
    assign bus.alu_result = res_q;
    assign bus.zero_flag  = zero_q;
    assign bus.overflow   = ovf_q;
`ifdef ALU_STICKY_OVF_EN
    logic sticky_d, sticky_q;
    // Setting from the registered flag means a same-cycle clear loses.
    assign sticky_d = ovf_q | (sticky_q & ~bus.ovf_clr);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
    assign bus.ovf_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed vectors into a scoreboard queue, checked by a separate monitor.
module tb_mips_alu;
    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        string       name;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic issue = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    mips_alu_if bus();
    mips_alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic z, input logic o, input string name);
        exp_t e;
        @(negedge clk);
        bus.alu_op = op;
        bus.data1  = a;
        bus.data2  = b;
        issue      = 1'b1;
        e.res = r; e.zero = z; e.ovf = o; e.name = name;
        q.push_back(e);
    endtask
    task automatic idle();
        @(negedge clk);
        issue = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask
    // Monitor: a vector issued before an edge must be visible just after it.
    initial begin
        logic pend;
        exp_t e;
        forever begin
            @(posedge clk);
            pend = issue;
            #1;
            if (pend) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard: output with queue empty, expected a pending entry");
                end else begin
                    e = q.pop_front();
                    check({e.name, ".res"},  bus.alu_result, e.res);
                    check({e.name, ".zero"}, {31'b0, bus.zero_flag}, {31'b0, e.zero});
                    check({e.name, ".ovf"},  {31'b0, bus.overflow},  {31'b0, e.ovf});
                end
            end
        end
    end
    initial begin
        bus.alu_op = 4'b0010;
        bus.data1  = 32'h7FFF_FFFF;
        bus.data2  = 32'h1;
`ifdef ALU_STICKY_OVF_EN
        bus.ovf_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst.res",  bus.alu_result, 32'h0);
        check("rst.zero", {31'b0, bus.zero_flag}, 32'h0);
        check("rst.ovf",  {31'b0, bus.overflow},  32'h0);
`ifdef ALU_STICKY_OVF_EN
        check("rst.sticky", {31'b0, bus.ovf_sticky}, 32'h0);
`endif
        rst_n = 1'b1;
        drive(4'b0010, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, "add");
        drive(4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        drive(4'b0101, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0, "addu");
        drive(4'b0110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1, "sub_ovf");
        drive(4'b0110, 32'd9,         32'd9,         32'h0,         1'b1, 1'b0, "sub_zero");
        drive(4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, "slt");
        drive(4'b1011, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, "sltu");
        drive(4'b1010, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, "sra");
        drive(4'b1001, 32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0, "srl");
        drive(4'b1000, 32'h25,        32'h1,         32'h20,        1'b0, 1'b0, "sll");
        drive(4'b1001, 32'h20,        32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, "srl0");
        drive(4'b1101, 32'h0,         32'h1234,      32'h1234_0000, 1'b0, 1'b0, "lui");
        drive(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, "and");
        drive(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, "or");
        drive(4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 1'b0, 1'b0, "nor");
        drive(4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b0, "xor");
        drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, "rsvd");
        drive(4'b1100, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, "subu");
        drive(4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, "sub_ovf2");
        drive(4'b1110, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, "passb");
        idle();
        drain();
        #3 rst_n = 1'b0;
        #1;
        check("midrst.res",  bus.alu_result, 32'h0);
        check("midrst.zero", {31'b0, bus.zero_flag}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, "add_after_rst");
        idle();
        drain();
`ifdef ALU_STICKY_OVF_EN
        drive(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, "st_ovf");
        drive(4'b0010, 32'd1,         32'd1, 32'd2,         1'b0, 1'b0, "st_clean");
        idle();
        @(negedge clk);
        check("sticky.hold", {31'b0, bus.ovf_sticky}, 32'h1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check("sticky.clr", {31'b0, bus.ovf_sticky}, 32'h0);
        drive(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, "st_ovf2");
        @(negedge clk);
        issue = 1'b0;
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check("sticky.setwins", {31'b0, bus.ovf_sticky}, 32'h1);
        drain();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
